// File: rtl/sram_rw_arbiter.sv
// Arbitrates one single-port RW SRAM macro between a read and a write requester.
// Zero-fills the array after reset; reads win unless a write has waited STARVE_MAX cycles.
module sram_rw_arbiter #(
  parameter int DEPTH      = 2048,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 60,
  parameter int MASK_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic [MASK_W-1:0] wr_req_mask,
  output logic              init_busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] init_addr;
  logic [CNT_W-1:0]  starve_cnt;
  logic              resp_vld_q;
  logic              in_init;
  logic              in_run;
  logic              wr_pri;
  logic              rd_fire;
  logic              wr_fire;

  // Gating with reset_n keeps the macro idle the instant reset asserts.
  assign init_busy = (state == ST_INIT);
  assign in_init   = reset_n & (state == ST_INIT);
  assign in_run    = reset_n & (state == ST_RUN);
  assign wr_pri    = (starve_cnt == CNT_W'(STARVE_MAX));

  assign rd_req_ready = in_run & (~wr_pri | ~wr_req_valid);
  assign wr_req_ready = in_run & (~rd_req_valid | wr_pri);
  assign rd_fire      = rd_req_valid & rd_req_ready;
  assign wr_fire      = wr_req_valid & wr_req_ready;

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (in_init) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_addr;
      sram_wmask = '1;
    end else if (wr_fire) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = wr_req_addr;
      sram_wmask = wr_req_mask;
      sram_wdata = wr_req_data;
    end else if (rd_fire) begin
      sram_en    = 1'b1;
      sram_addr  = rd_req_addr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_INIT;
      init_addr  <= '0;
      starve_cnt <= '0;
      resp_vld_q <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        init_addr <= init_addr + ADDR_W'(1);
        if (init_addr == ADDR_W'(DEPTH - 1)) state <= ST_RUN;
      end
      resp_vld_q <= rd_fire;
      if (!wr_req_valid || wr_fire) starve_cnt <= '0;
      else if (!wr_pri)             starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign rd_resp_valid = resp_vld_q;
  assign rd_resp_data  = resp_vld_q ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter: behavioural SRAM macro, reference memory/arbitration model,
// vector table, hand-written corner sequences and randomized traffic.
module tb_sram_rw_arbiter;

  localparam int DEPTH = 2048;
  localparam int SMAX  = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rd_req_valid, rd_req_ready, rd_resp_valid;
  logic [10:0] rd_req_addr;
  logic [59:0] rd_resp_data;
  logic        wr_req_valid, wr_req_ready;
  logic [10:0] wr_req_addr;
  logic [59:0] wr_req_data;
  logic [9:0]  wr_req_mask;
  logic        init_busy;
  logic [10:0] sram_addr;
  logic        sram_en, sram_wmode;
  logic [9:0]  sram_wmask;
  logic [59:0] sram_wdata;
  logic [59:0] sram_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  sram_rw_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_mask(wr_req_mask), .init_busy(init_busy),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural macro: masked writes, registered read data.
  logic [59:0] mem [0:DEPTH-1];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < 10; l++)
          if (sram_wmask[l]) mem[sram_addr][l*6 +: 6] <= sram_wdata[l*6 +: 6];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  // Reference model state
  logic [59:0] ref_mem [0:DEPTH-1];
  int          waited;
  logic        exp_rv;
  logic [59:0] exp_rd;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    waited = 0;
    exp_rv = 1'b0;
    exp_rd = '0;
  endtask

  // Called at the negedge with inputs stable for the current cycle.
  task automatic model_cycle();
    logic        wg, rg, starved;
    logic [82:0] bus;
    logic [59:0] merged;
    starved = (waited >= SMAX);
    wg = wr_req_valid && (!rd_req_valid || starved);
    rg = rd_req_valid && !wg;
    bus = '0;
    if (wg)      bus = {1'b1, 1'b1, wr_req_addr, wr_req_mask, wr_req_data};
    else if (rg) bus = {1'b1, 1'b0, rd_req_addr, 10'h0, 60'h0};
    check("model_rd_ready", 128'(rd_req_ready), 128'(!starved || !wr_req_valid));
    check("model_wr_ready", 128'(wr_req_ready), 128'(!rd_req_valid || starved));
    check("model_sram_bus", 128'({sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}), 128'(bus));
    check("model_resp_valid", 128'(rd_resp_valid), 128'(exp_rv));
    check("model_resp_data", 128'(rd_resp_data), 128'(exp_rv ? exp_rd : 60'h0));
    exp_rv = rg;
    exp_rd = ref_mem[rd_req_addr];
    if (wg) begin
      merged = ref_mem[wr_req_addr];
      for (int l = 0; l < 10; l++)
        if (wr_req_mask[l]) merged[l*6 +: 6] = wr_req_data[l*6 +: 6];
      ref_mem[wr_req_addr] = merged;
    end
    if (wg || !wr_req_valid) waited = 0;
    else if (waited < SMAX)  waited = waited + 1;
  endtask

  task automatic set_in(input logic rv, input logic [10:0] ra, input logic wv,
                        input logic [10:0] wa, input logic [59:0] wd, input logic [9:0] wm);
    rd_req_valid = rv; rd_req_addr = ra;
    wr_req_valid = wv; wr_req_addr = wa; wr_req_data = wd; wr_req_mask = wm;
  endtask

  task automatic finish_cycle();
    model_cycle();
    @(posedge clock); #1;
  endtask

  // Runs the whole zero-fill window, then checks the first RUN cycle.
  task automatic init_seq();
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_addr !== 11'(i) ||
          sram_wmask !== 10'h3FF || sram_wdata !== 60'h0 || init_busy !== 1'b1 ||
          rd_req_ready !== 1'b0 || wr_req_ready !== 1'b0)
        bad++;
      @(posedge clock); #1;
    end
    check("init_seq_bad_cycles", 128'(bad), 128'(0));
    @(negedge clock);
    check("init_done", 128'(init_busy), 128'(0));
    finish_cycle();
  endtask

  typedef struct {
    logic        rv;
    logic [10:0] ra;
    logic        wv;
    logic [10:0] wa;
    logic [59:0] wd;
    logic [9:0]  wm;
    logic        erd;
    logic        ewr;
    logic        ev;
    logic [59:0] ed;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom} & 60'hFFF_FFFF_FFFF_FFFF;
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    tbl[0] = '{1'b1, 11'h005, 1'b0, 11'h000, 60'h0, 10'h000, 1'b1, 1'b0, 1'b0, 60'h0};
    tbl[1] = '{1'b0, 11'h000, 1'b1, 11'h123, 60'h0ABCDEF01234567, 10'h3FF, 1'b1, 1'b1, 1'b1, 60'h0};
    tbl[2] = '{1'b1, 11'h123, 1'b0, 11'h000, 60'h0, 10'h000, 1'b1, 1'b0, 1'b0, 60'h0};
    tbl[3] = '{1'b0, 11'h000, 1'b1, 11'h010, 60'hFFF_FFFF_FFFF_FFFF, 10'h001, 1'b1, 1'b1, 1'b1, 60'h0ABCDEF01234567};
    tbl[4] = '{1'b1, 11'h010, 1'b0, 11'h000, 60'h0, 10'h000, 1'b1, 1'b0, 1'b0, 60'h0};
    tbl[5] = '{1'b0, 11'h000, 1'b1, 11'h200, 60'h1, 10'h3FF, 1'b1, 1'b1, 1'b1, 60'h3F};
    tbl[6] = '{1'b1, 11'h200, 1'b0, 11'h000, 60'h0, 10'h000, 1'b1, 1'b0, 1'b0, 60'h0};
    tbl[7] = '{1'b0, 11'h000, 1'b1, 11'h200, 60'h2, 10'h3FF, 1'b1, 1'b1, 1'b1, 60'h1};
    tbl[8] = '{1'b1, 11'h200, 1'b0, 11'h000, 60'h0, 10'h000, 1'b1, 1'b0, 1'b0, 60'h0};
    tbl[9] = '{1'b0, 11'h000, 1'b0, 11'h000, 60'h0, 10'h000, 1'b1, 1'b1, 1'b1, 60'h2};

    // Reset state and zero-fill
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_init_busy", 128'(init_busy), 128'(1));
    check("rst_readies", 128'({rd_req_ready, wr_req_ready}), 128'(0));
    check("rst_sram_bus", 128'({sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}), 128'(0));
    check("rst_resp_valid", 128'(rd_resp_valid), 128'(0));
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();
    init_seq();

    // Vector table: zero read, full/masked writes, read-after-write, read-before-write
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].rv, tbl[i].ra, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].wm);
      @(negedge clock);
      check($sformatf("tbl%0d_rd_ready", i), 128'(rd_req_ready), 128'(tbl[i].erd));
      check($sformatf("tbl%0d_wr_ready", i), 128'(wr_req_ready), 128'(tbl[i].ewr));
      check($sformatf("tbl%0d_resp_valid", i), 128'(rd_resp_valid), 128'(tbl[i].ev));
      check($sformatf("tbl%0d_resp_data", i), 128'(rd_resp_data), 128'(tbl[i].ed));
      finish_cycle();
    end

    // Contention: write wins every fifth cycle
    for (int k = 0; k < 20; k++) begin
      set_in(1'b1, 11'h310 + 11'(k), 1'b1, 11'h300 + 11'(k % 8),
             60'({$urandom, $urandom}), 10'h3FF);
      @(negedge clock);
      check($sformatf("starve%0d_rd_ready", k), 128'(rd_req_ready), 128'(k % 5 != 4));
      check($sformatf("starve%0d_wr_ready", k), 128'(wr_req_ready), 128'(k % 5 == 4));
      if (rd_req_ready && wr_req_ready) begin
        n_tests++; n_fail++;
        $display("FAIL starve%0d_both_ready: got both ready, expected at most one", k);
      end
      finish_cycle();
    end

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      set_in(1'($urandom_range(0, 1)), 11'h300 + 11'($urandom_range(0, 7)),
             $urandom_range(0, 9) < 7, 11'h300 + 11'($urandom_range(0, 7)),
             60'({$urandom, $urandom}), 10'($urandom));
      @(negedge clock);
      finish_cycle();
    end

    // Reset pulsed mid zero-fill at address 100
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clock); #2;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (100) @(posedge clock);
    @(negedge clock);
    check("midinit_addr", 128'(sram_addr), 128'(100));
    #2 reset_n = 1'b0;
    #1;
    check("midinit_rst_en", 128'(sram_en), 128'(0));
    check("midinit_rst_busy", 128'(init_busy), 128'(1));
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();
    init_seq();
    set_in(1'b1, 11'h300, 1'b0, 0, 0, 0);
    @(negedge clock);
    finish_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    check("refill_resp_valid", 128'(rd_resp_valid), 128'(1));
    check("refill_resp_zero", 128'(rd_resp_data), 128'(0));
    finish_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
